// File: rtl/frame_fwd_engine.sv
// rtl/frame_fwd_engine.sv - per-frame forwarding: MAC extract, one lookup, byte stream, egress pointer
module frame_fwd_engine #(
    parameter int LEN_W   = 11,
    parameter int NPORT   = 4,
    parameter int MIN_LEN = 14
) (
    input  logic                   clk_sys,
    input  logic                   rstn_sys,
    input  logic                   ptr_sfifo_empty,
    output logic                   ptr_sfifo_rd,
    input  logic [NPORT+LEN_W:0]   ptr_sfifo_dout,
    output logic                   sfifo_rd,
    input  logic [7:0]             sfifo_dout,
    output logic                   se_req,
    output logic [47:0]            se_dmac,
    output logic [47:0]            se_smac,
    output logic [NPORT-1:0]       se_src_port,
    input  logic                   se_ack,
    input  logic                   se_nak,
    input  logic [NPORT-1:0]       se_portmap,
    input  logic                   o_bp,
    output logic                   o_data_wr,
    output logic [7:0]             o_data,
    output logic                   o_ptr_wr,
    output logic [NPORT+LEN_W:0]   o_ptr
);

    typedef enum logic [2:0] {S_IDLE, S_PRD, S_PLAT, S_DATA, S_WAIT, S_PWR} state_t;

    localparam logic [LEN_W-1:0] MIN_LEN_L  = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] DMAC_END   = LEN_W'(6);
    localparam logic [LEN_W-1:0] SMAC_END   = LEN_W'(12);
    localparam logic [LEN_W-1:0] LAST_MAC   = LEN_W'(11);
    localparam logic [NPORT-1:0] ALL_PORTS  = {NPORT{1'b1}};

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   rd_cnt_q;
    logic [LEN_W-1:0]   byte_cnt_q;
    logic [NPORT-1:0]   src_q;
    logic [NPORT-1:0]   portmap_q;
    logic               runt_q;
    logic               rd_d1_q;
    logic               res_valid_q;
    logic               se_req_q;
    logic               o_data_wr_q;
    logic [7:0]         o_data_q;
    logic [47:0]        dmac_q;
    logic [47:0]        smac_q;
    logic               pop_byte;
    logic               result;
    logic               start;
    logic               unused_ptr_msb;

    assign unused_ptr_msb = ptr_sfifo_dout[NPORT+LEN_W];

    // Byte pops run back to back until the full frame length has been requested.
    assign pop_byte = (state_q == S_DATA) && (rd_cnt_q != len_q);
    // Only an outstanding request can be answered; stray pulses are ignored.
    assign result   = se_req_q && (se_ack || se_nak);
    assign start    = !ptr_sfifo_empty && !o_bp;

    // Next-state logic for the per-frame sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_PRD;
            S_PRD:   state_d = S_PLAT;
            S_PLAT:  state_d = S_DATA;
            S_DATA:  if ((rd_cnt_q == len_q) && !rd_d1_q) state_d = S_WAIT;
            S_WAIT:  if (runt_q || res_valid_q || result) state_d = S_PWR;
            S_PWR:   state_d = start ? S_PRD : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Frame context, byte pipeline, MAC capture and lookup handshake.
    always_ff @(posedge clk_sys or negedge rstn_sys) begin
        if (!rstn_sys) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            rd_cnt_q    <= '0;
            byte_cnt_q  <= '0;
            src_q       <= '0;
            portmap_q   <= '0;
            runt_q      <= 1'b0;
            rd_d1_q     <= 1'b0;
            res_valid_q <= 1'b0;
            se_req_q    <= 1'b0;
            o_data_wr_q <= 1'b0;
            o_data_q    <= '0;
            dmac_q      <= '0;
            smac_q      <= '0;
        end else begin
            state_q     <= state_d;
            rd_d1_q     <= pop_byte;
            o_data_wr_q <= rd_d1_q && !runt_q;
            if (rd_d1_q) begin
                o_data_q <= sfifo_dout;
            end
            if (state_q == S_PLAT) begin
                len_q       <= ptr_sfifo_dout[LEN_W-1:0];
                src_q       <= ptr_sfifo_dout[NPORT+LEN_W-1:LEN_W];
                runt_q      <= ptr_sfifo_dout[LEN_W-1:0] < MIN_LEN_L;
                rd_cnt_q    <= '0;
                byte_cnt_q  <= '0;
                res_valid_q <= 1'b0;
                portmap_q   <= '0;
            end
            if (pop_byte) begin
                rd_cnt_q <= rd_cnt_q + 1'b1;
            end
            if (rd_d1_q) begin
                byte_cnt_q <= byte_cnt_q + 1'b1;
                if (byte_cnt_q < DMAC_END) begin
                    dmac_q <= {dmac_q[39:0], sfifo_dout};
                end else if (byte_cnt_q < SMAC_END) begin
                    smac_q <= {smac_q[39:0], sfifo_dout};
                end
                if ((byte_cnt_q == LAST_MAC) && !runt_q) begin
                    se_req_q <= 1'b1;
                end
            end
            // A simultaneous ack and nak resolves as a hit.
            if (result) begin
                se_req_q    <= 1'b0;
                res_valid_q <= 1'b1;
                portmap_q   <= (se_ack ? se_portmap : ALL_PORTS) & ~src_q;
            end
        end
    end

    assign ptr_sfifo_rd = (state_q == S_PRD);
    assign sfifo_rd     = pop_byte;
    assign se_req       = se_req_q;
    assign se_dmac      = dmac_q;
    assign se_smac      = smac_q;
    assign se_src_port  = src_q;
    assign o_data_wr    = o_data_wr_q;
    assign o_data       = o_data_q;
    assign o_ptr_wr     = (state_q == S_PWR) && !runt_q;
    assign o_ptr        = o_ptr_wr ? {portmap_q, 1'b0, len_q} : '0;

endmodule

// File: tb/tb_frame_fwd_engine.sv
// tb/tb_frame_fwd_engine.sv - directed bench for frame_fwd_engine
module tb_frame_fwd_engine;

    logic        clk_sys = 1'b0;
    logic        rstn_sys = 1'b0;
    logic        ptr_sfifo_empty = 1'b1;
    logic        ptr_sfifo_rd;
    logic [15:0] ptr_sfifo_dout = '0;
    logic        sfifo_rd;
    logic [7:0]  sfifo_dout = '0;
    logic        se_req;
    logic [47:0] se_dmac;
    logic [47:0] se_smac;
    logic [3:0]  se_src_port;
    logic        se_ack = 1'b0;
    logic        se_nak = 1'b0;
    logic [3:0]  se_portmap = '0;
    logic        o_bp = 1'b0;
    logic        o_data_wr;
    logic [7:0]  o_data;
    logic        o_ptr_wr;
    logic [15:0] o_ptr;

    frame_fwd_engine dut (
        .clk_sys(clk_sys), .rstn_sys(rstn_sys),
        .ptr_sfifo_empty(ptr_sfifo_empty), .ptr_sfifo_rd(ptr_sfifo_rd), .ptr_sfifo_dout(ptr_sfifo_dout),
        .sfifo_rd(sfifo_rd), .sfifo_dout(sfifo_dout),
        .se_req(se_req), .se_dmac(se_dmac), .se_smac(se_smac), .se_src_port(se_src_port),
        .se_ack(se_ack), .se_nak(se_nak), .se_portmap(se_portmap),
        .o_bp(o_bp), .o_data_wr(o_data_wr), .o_data(o_data), .o_ptr_wr(o_ptr_wr), .o_ptr(o_ptr)
    );

    always #5 clk_sys = ~clk_sys;

    int tests_run = 0;
    int tests_failed = 0;

    logic [15:0] ptr_q[$];
    logic [7:0]  byte_q[$];
    logic [7:0]  got_bytes[$];
    logic [15:0] got_ptrs[$];
    logic [47:0] got_dmac[$];
    logic [47:0] got_smac[$];
    logic [7:0]  exp_bytes[$];
    logic [15:0] exp_ptrs[$];
    logic [47:0] exp_dmac[$];
    logic [47:0] exp_smac[$];
    int exp_rd, exp_pops;
    int n_rd, n_ptr_rd, n_req;
    int se_delay, se_cnt;
    bit se_mode_nak, se_done, se_req_prev;
    logic [3:0] se_pm;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Ingress FIFO models: pop on rd, data valid the following cycle.
    always @(posedge clk_sys) begin
        if (ptr_sfifo_rd && ptr_q.size() > 0) ptr_sfifo_dout <= ptr_q.pop_front();
        if (sfifo_rd && byte_q.size() > 0) sfifo_dout <= byte_q.pop_front();
        ptr_sfifo_empty <= (ptr_q.size() == 0);
    end

    // Output monitor and lookup responder.
    always @(negedge clk_sys) begin
        se_ack = 1'b0;
        se_nak = 1'b0;
        if (rstn_sys) begin
            if (ptr_sfifo_rd) n_ptr_rd++;
            if (sfifo_rd) n_rd++;
            if (o_data_wr) got_bytes.push_back(o_data);
            if (o_ptr_wr) got_ptrs.push_back(o_ptr);
            if (se_req && !se_req_prev) begin
                n_req++;
                got_dmac.push_back(se_dmac);
                got_smac.push_back(se_smac);
            end
            se_req_prev = se_req;
            if (!se_req) begin
                se_done = 1'b0;
                se_cnt = 0;
            end else if (!se_done) begin
                if (se_cnt >= se_delay) begin
                    se_done = 1'b1;
                    se_portmap = se_pm;
                    if (se_mode_nak) se_nak = 1'b1;
                    else se_ack = 1'b1;
                end else begin
                    se_cnt++;
                end
            end
        end
    end

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic clear_all();
        got_bytes.delete(); got_ptrs.delete(); got_dmac.delete(); got_smac.delete();
        exp_bytes.delete(); exp_ptrs.delete(); exp_dmac.delete(); exp_smac.delete();
        exp_rd = 0; exp_pops = 0; n_rd = 0; n_ptr_rd = 0; n_req = 0;
    endtask

    task automatic push_frame(input logic [10:0] len, input logic [3:0] src, input logic [15:0] eptr);
        logic [7:0]  b;
        logic [47:0] d, s;
        d = '0; s = '0;
        for (int i = 0; i < int'(len); i++) begin
            b = 8'($urandom);
            byte_q.push_back(b);
            if (len >= 11'd14) exp_bytes.push_back(b);
            if (i < 6) d = {d[39:0], b};
            else if (i < 12) s = {s[39:0], b};
        end
        if (len >= 11'd14) begin
            exp_ptrs.push_back(eptr);
            exp_dmac.push_back(d);
            exp_smac.push_back(s);
        end
        exp_rd += int'(len);
        exp_pops++;
        ptr_q.push_back({1'b0, src, len});
    endtask

    task automatic wait_ptrs(input int budget);
        int k;
        k = 0;
        while (got_ptrs.size() < exp_ptrs.size() && k < budget) begin
            cycles(1);
            k++;
        end
    endtask

    task automatic verify(input string tag);
        int mism;
        check({tag, "_ptr_cnt"}, 64'(got_ptrs.size()), 64'(exp_ptrs.size()));
        for (int i = 0; i < got_ptrs.size() && i < exp_ptrs.size(); i++)
            check({tag, "_ptr"}, 64'(got_ptrs[i]), 64'(exp_ptrs[i]));
        check({tag, "_byte_cnt"}, 64'(got_bytes.size()), 64'(exp_bytes.size()));
        mism = 0;
        for (int i = 0; i < got_bytes.size() && i < exp_bytes.size(); i++)
            if (got_bytes[i] !== exp_bytes[i]) mism++;
        check({tag, "_data"}, 64'(mism), 64'd0);
        check({tag, "_sfifo_rd"}, 64'(n_rd), 64'(exp_rd));
        check({tag, "_ptr_pop"}, 64'(n_ptr_rd), 64'(exp_pops));
        check({tag, "_se_req"}, 64'(n_req), 64'(exp_dmac.size()));
        for (int i = 0; i < got_dmac.size() && i < exp_dmac.size(); i++) begin
            check({tag, "_dmac"}, 64'(got_dmac[i]), 64'(exp_dmac[i]));
            check({tag, "_smac"}, 64'(got_smac[i]), 64'(exp_smac[i]));
        end
    endtask

    task automatic frame_test(input string tag, input logic [10:0] len, input logic [3:0] src,
                              input bit nak, input logic [3:0] pm, input int dly, input logic [15:0] eptr);
        clear_all();
        se_mode_nak = nak; se_pm = pm; se_delay = dly;
        push_frame(len, src, eptr);
        wait_ptrs(int'(len) + dly + 100);
        cycles(int'(len) + 30);
        verify(tag);
    endtask

    initial begin
        se_delay = 3; se_pm = '0; se_mode_nak = 1'b0; se_cnt = 0; se_done = 1'b0; se_req_prev = 1'b0;
        clear_all();
        cycles(3);
        check("rst_ptr_wr", 64'(o_ptr_wr), 64'd0);
        check("rst_data_wr", 64'(o_data_wr), 64'd0);
        check("rst_se_req", 64'(se_req), 64'd0);
        check("rst_ptr_rd", 64'(ptr_sfifo_rd), 64'd0);
        check("rst_sfifo_rd", 64'(sfifo_rd), 64'd0);
        check("rst_o_ptr", 64'(o_ptr), 64'd0);
        check("rst_dmac", 64'(se_dmac), 64'd0);
        rstn_sys = 1'b1;
        cycles(2);

        frame_test("uni64",   11'd64, 4'b0001, 1'b0, 4'b0100, 3, 16'h4040);
        frame_test("miss",    11'd64, 4'b0010, 1'b1, 4'b0000, 3, 16'hD040);
        frame_test("own",     11'd64, 4'b0001, 1'b0, 4'b0001, 3, 16'h0040);
        frame_test("runt10",  11'd10, 4'b0001, 1'b0, 4'b0100, 3, 16'h0000);
        frame_test("runt0",   11'd0,  4'b0001, 1'b0, 4'b0100, 3, 16'h0000);
        frame_test("runt13",  11'd13, 4'b0001, 1'b0, 4'b0100, 3, 16'h0000);
        frame_test("min14",   11'd14, 4'b1000, 1'b0, 4'b1111, 0, 16'h700E);

        // Backpressure holds a pending pointer; release starts the frame promptly.
        clear_all();
        se_mode_nak = 1'b0; se_pm = 4'b0001; se_delay = 3;
        o_bp = 1'b1;
        push_frame(11'd64, 4'b0100, 16'h1040);
        cycles(10);
        check("bp_hold_pop", 64'(n_ptr_rd), 64'd0);
        o_bp = 1'b0;
        cycles(2);
        check("bp_release_pop", 64'(n_ptr_rd), 64'd1);
        wait_ptrs(200);
        cycles(10);
        verify("bp");

        // Slow lookup: the engine parks in WAIT until the ack.
        clear_all();
        se_mode_nak = 1'b0; se_pm = 4'b0110; se_delay = 100;
        push_frame(11'd60, 4'b0010, 16'h403C);
        cycles(90);
        check("slow_noptr_yet", 64'(got_ptrs.size()), 64'd0);
        check("slow_req_held", 64'(se_req), 64'd1);
        wait_ptrs(200);
        cycles(20);
        verify("slow");

        // Back-to-back frames, both queued before the first starts.
        clear_all();
        se_mode_nak = 1'b0; se_pm = 4'b0010; se_delay = 2;
        push_frame(11'd1518, 4'b0001, 16'h25EE);
        push_frame(11'd64, 4'b0001, 16'h2040);
        wait_ptrs(2000);
        cycles(20);
        verify("b2b");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
